// File: rtl/seeg_stream_batcher.sv
// seeg_stream_batcher: packs multi-channel sEEG sample frames into 32-bit tagged
// AXI-Stream beats {frame_seq, ch_idx, sample}. Frames are grouped into batches
// closed by TLAST. A frame is dropped as a whole when the FIFO lacks room or the
// serialiser is still busy.
// Optional feature macro: SEEG_STREAM_LOOPBACK_EN (counter pattern replaces samples).
module seeg_stream_batcher #(
    parameter int NUM_CH     = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                 M_AXIS_ACLK,
    input  logic                 M_AXIS_ARESETN,
    input  logic                 record_start,
    input  logic                 record_stop,
    input  logic [15:0]          batch_size,
    input  logic                 loopback,
    input  logic                 frame_valid,
    input  logic [NUM_CH*16-1:0] frame_data,
    output logic [31:0]          M_AXIS_tdata,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic                 M_AXIS_tlast,
    output logic                 recording,
    output logic [31:0]          drop_count,
    output logic                 overflow
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t               state, state_nxt;
    logic [7:0]           frame_seq;
    logic [15:0]          batch_cnt;
    logic [15:0]          bs_q;
    logic [15:0]          bs_last;
    logic                 batch_last;

    // serialiser stage registers
    logic                 busy_p1;
    logic [CHW-1:0]       ch_p1;
    logic [NUM_CH*16-1:0] shadow_p1;
    logic [7:0]           seq_p1;
    logic                 last_frm_p1;

    // FIFO
    logic [32:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [32:0]          head;

    logic                 last_beat, wr_en, wr_last, rd_en;
    logic                 ser_free, space_ok, active, stop_block, idle_now;
    logic                 accept, drop;
    logic [CW:0]          need;
    logic [15:0]          ch_data, sample;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bs_last    = (bs_q == 16'd0) ? 16'd0 : bs_q - 16'd1;
    assign batch_last = (batch_cnt == bs_last);

    assign last_beat  = busy_p1 && (ch_p1 == CHW'(NUM_CH - 1));
    assign wr_en      = busy_p1;
    assign wr_last    = last_beat && last_frm_p1;
    assign ser_free   = !busy_p1 || last_beat;
    // the beat still being written this cycle counts against free space
    assign need       = {1'b0, count} + (CW+1)'(last_beat) + (CW+1)'(NUM_CH);
    assign space_ok   = (need <= (CW+1)'(FIFO_DEPTH));
    assign active     = (state != IDLE);
    // frames arriving as STOPPING closes its batch, or as RUN stops cleanly, are ignored
    assign stop_block = (state == STOPPING) && wr_last && !record_start;
    assign idle_now   = (state == RUN) && record_stop && !record_start &&
                        (batch_cnt == 16'd0) && !busy_p1;
    assign accept     = frame_valid && active && !stop_block && !idle_now && ser_free && space_ok;
    assign drop       = frame_valid && active && !stop_block && !idle_now && !accept;

    assign ch_data    = shadow_p1[{ch_p1, 4'b0000} +: 16];

    assign head          = mem[rd_ptr];
    assign M_AXIS_tvalid = (count != '0);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? head[31:0] : 32'd0;
    assign M_AXIS_tlast  = M_AXIS_tvalid && head[32];
    assign rd_en         = M_AXIS_tvalid && M_AXIS_tready;
    assign recording     = active;

`ifdef SEEG_STREAM_LOOPBACK_EN
    logic        lb_q;
    logic [15:0] lb_cnt;

    // loopback mode latch and per-beat counter pattern
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            lb_q   <= 1'b0;
            lb_cnt <= 16'd0;
        end else if (record_start) begin
            lb_q   <= loopback;
            lb_cnt <= 16'd0;
        end else if (wr_en && lb_q) begin
            lb_cnt <= lb_cnt + 16'd1;
        end
    end

    assign sample = lb_q ? lb_cnt : ch_data;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign sample          = ch_data;
`endif

    // next-state logic: start wins over stop, stop waits for a batch boundary
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (record_start) state_nxt = RUN;
            end
            RUN: begin
                if (record_start)
                    state_nxt = RUN;
                else if (record_stop)
                    state_nxt = ((batch_cnt == 16'd0) && !busy_p1) ? IDLE : STOPPING;
            end
            STOPPING: begin
                if (record_start)
                    state_nxt = RUN;
                else if (wr_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // control state: FSM, serialiser sequencing, FIFO pointers and counters
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state      <= IDLE;
            busy_p1    <= 1'b0;
            ch_p1      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_seq  <= 8'd0;
            batch_cnt  <= 16'd0;
            bs_q       <= 16'd0;
            drop_count <= 32'd0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                busy_p1 <= 1'b1;
                ch_p1   <= '0;
            end else if (busy_p1) begin
                if (last_beat) busy_p1 <= 1'b0;
                else           ch_p1   <= ch_p1 + 1'b1;
            end

            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);

            if (record_start) begin
                frame_seq  <= 8'd0;
                batch_cnt  <= 16'd0;
                bs_q       <= batch_size;
                drop_count <= 32'd0;
                overflow   <= 1'b0;
            end else begin
                if (accept) begin
                    frame_seq <= frame_seq + 8'd1;
                    batch_cnt <= batch_last ? 16'd0 : batch_cnt + 16'd1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
                end
            end
        end
    end

    // ---- p0 -> p1: capture frame and its tags into the shadow register ----
    always_ff @(posedge M_AXIS_ACLK) begin
        if (accept) begin
            shadow_p1   <= frame_data;
            seq_p1      <= frame_seq;
            last_frm_p1 <= batch_last;
        end
    end

    // ---- p1 -> FIFO: one tagged beat per cycle ----
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en) mem[wr_ptr] <= {wr_last, seq_p1, 8'(ch_p1), sample};
    end

endmodule

// File: tb/tb_seeg_stream_batcher.sv
// tb_seeg_stream_batcher: directed bench for seeg_stream_batcher (NUM_CH=4, FIFO_DEPTH=16).
module tb_seeg_stream_batcher;

    localparam int NCH   = 4;
    localparam int DEPTH = 16;
`ifdef SEEG_STREAM_LOOPBACK_EN
    localparam bit LB_ON = 1'b1;
`else
    localparam bit LB_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               record_start = 1'b0;
    logic               record_stop = 1'b0;
    logic [15:0]        batch_size = 16'd0;
    logic               loopback = 1'b0;
    logic               frame_valid = 1'b0;
    logic [NCH*16-1:0]  frame_data = '0;
    logic [31:0]        tdata;
    logic               tvalid;
    logic               tready = 1'b0;
    logic               tlast;
    logic               recording;
    logic [31:0]        drop_count;
    logic               overflow;

    int                 checks = 0;
    int                 errors = 0;
    logic [32:0]        beats[$];

    seeg_stream_batcher #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rstn),
        .record_start   (record_start),
        .record_stop    (record_stop),
        .batch_size     (batch_size),
        .loopback       (loopback),
        .frame_valid    (frame_valid),
        .frame_data     (frame_data),
        .M_AXIS_tdata   (tdata),
        .M_AXIS_tvalid  (tvalid),
        .M_AXIS_tready  (tready),
        .M_AXIS_tlast   (tlast),
        .recording      (recording),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // record every transfer; sampled mid-cycle, the transfer completes on the next rising edge
    always @(negedge clk) begin
        if (rstn && tvalid && tready) beats.push_back({tlast, tdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] smp(input int f, input int k);
        return 16'hC000 | 16'((f & 255) << 4) | 16'(k);
    endfunction

    function automatic logic [NCH*16-1:0] mkframe(input int f);
        logic [NCH*16-1:0] d;
        for (int k = 0; k < NCH; k++) d[16*k +: 16] = smp(f, k);
        return d;
    endfunction

    function automatic logic [32:0] bt(input logic l, input int seq, input int ch, input logic [15:0] s);
        return {l, 8'(seq), 8'(ch), s};
    endfunction

    task automatic do_start(input int bs, input logic lb);
        batch_size   = 16'(bs);
        loopback     = lb;
        record_start = 1'b1;
        tick(1);
        record_start = 1'b0;
    endtask

    task automatic do_stop();
        record_stop = 1'b1;
        tick(1);
        record_stop = 1'b0;
    endtask

    task automatic send(input int f);
        frame_valid = 1'b1;
        frame_data  = mkframe(f);
        tick(1);
        frame_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int c = 0;
        while (beats.size() < n && c < 200) begin
            tick(1);
            c++;
        end
        chk(tag, 64'(beats.size() >= n), 64'd1);
    endtask

    initial begin
        logic [15:0] s;
        int          f, k;

        // reset state
        rstn = 1'b0;
        tick(3);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_recording", 64'(recording), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        rstn = 1'b1;
        tick(2);

        // 8 frames, batch 4, loopback requested, full throughput
        tready = 1'b1;
        do_start(4, 1'b1);
        chk("t1_recording", 64'(recording), 64'd1);
        beats.delete();
        send(0);
        chk("t1_lat_t1", 64'(tvalid), 64'd0);
        tick(1);
        chk("t1_lat_t2", 64'(tvalid), 64'd1);
        chk("t1_lat_data", 64'(tdata), 64'({8'd0, 8'd0, (LB_ON ? 16'd0 : smp(0, 0))}));
        tick(8);
        for (int i = 1; i < 8; i++) begin
            send(i);
            tick(9);
        end
        wait_beats(32, "t1_wait");
        chk("t1_count", 64'(beats.size()), 64'd32);
        for (int i = 0; i < 32 && i < beats.size(); i++) begin
            f = i / NCH;
            k = i % NCH;
            s = LB_ON ? 16'(i) : smp(f, k);
            chk($sformatf("t1_beat%0d", i), 64'(beats[i]), 64'(bt((i == 15) || (i == 31), f, k, s)));
        end
        chk("t1_drop", 64'(drop_count), 64'd0);
        do_stop();
        chk("t1_stop_idle", 64'(recording), 64'd0);

        // overflow: stalled sink, 6 frames into a 16-beat FIFO
        tready = 1'b0;
        do_start(4, 1'b0);
        beats.delete();
        for (int i = 0; i < 6; i++) begin
            send(i);
            tick(5);
        end
        chk("t2_drop", 64'(drop_count), 64'd2);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_tvalid", 64'(tvalid), 64'd1);
        chk("t2_nobeats", 64'(beats.size()), 64'd0);
        tick(3);
        chk("t2_stall_data", 64'(tdata), 64'({8'd0, 8'd0, smp(0, 0)}));
        chk("t2_stall_last", 64'(tlast), 64'd0);
        tready = 1'b1;
        wait_beats(16, "t2_wait");
        tick(5);
        chk("t2_count", 64'(beats.size()), 64'd16);
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            f = i / NCH;
            k = i % NCH;
            chk($sformatf("t2_beat%0d", i), 64'(beats[i]), 64'(bt(i == 15, f, k, smp(f, k))));
        end
        do_stop();
        chk("t2_stop_idle", 64'(recording), 64'd0);

        // batch_size 0 behaves as 1: TLAST on every frame's last channel
        do_start(0, 1'b0);
        chk("t3_overflow_clr", 64'(overflow), 64'd0);
        beats.delete();
        for (int i = 0; i < 3; i++) begin
            send(10 + i);
            tick(5);
        end
        wait_beats(12, "t3_wait");
        for (int i = 0; i < 12 && i < beats.size(); i++) begin
            f = i / NCH;
            k = i % NCH;
            chk($sformatf("t3_beat%0d", i), 64'(beats[i]), 64'(bt(k == NCH - 1, f, k, smp(10 + f, k))));
        end
        chk("t3_drop", 64'(drop_count), 64'd0);
        do_stop();

        // batch-aligned stop after 2 of 4 frames
        do_start(4, 1'b0);
        beats.delete();
        send(20);
        tick(5);
        send(21);
        tick(5);
        do_stop();
        chk("t4_stopping", 64'(recording), 64'd1);
        send(22);
        tick(5);
        send(23);
        tick(8);
        chk("t4_idle", 64'(recording), 64'd0);
        send(24);
        tick(8);
        chk("t4_count", 64'(beats.size()), 64'd16);
        chk("t4_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 16 && i < beats.size(); i++) begin
            f = i / NCH;
            k = i % NCH;
            chk($sformatf("t4_beat%0d", i), 64'(beats[i]), 64'(bt(i == 15, f, k, smp(20 + f, k))));
        end

        // busy drop 2 cycles after an accepted frame; next frame at minimum spacing accepted
        do_start(4, 1'b0);
        beats.delete();
        send(30);
        tick(1);
        send(31);
        tick(1);
        send(32);
        wait_beats(8, "t5_wait");
        tick(4);
        chk("t5_count", 64'(beats.size()), 64'd8);
        chk("t5_drop", 64'(drop_count), 64'd1);
        chk("t5_overflow", 64'(overflow), 64'd1);
        for (int i = 0; i < 8 && i < beats.size(); i++) begin
            f = i / NCH;
            k = i % NCH;
            chk($sformatf("t5_beat%0d", i), 64'(beats[i]), 64'(bt(1'b0, f, k, smp((f == 0) ? 30 : 32, k))));
        end

        // reset with beats queued
        tready = 1'b0;
        do_start(4, 1'b0);
        beats.delete();
        send(40);
        tick(1);
        send(49);
        tick(4);
        send(41);
        tick(5);
        send(42);
        tick(5);
        chk("t6_pre_drop", 64'(drop_count), 64'd1);
        chk("t6_pre_tvalid", 64'(tvalid), 64'd1);
        rstn = 1'b0;
        tick(1);
        chk("t6_rst_tvalid", 64'(tvalid), 64'd0);
        chk("t6_rst_tdata", 64'(tdata), 64'd0);
        chk("t6_rst_drop", 64'(drop_count), 64'd0);
        chk("t6_rst_recording", 64'(recording), 64'd0);
        rstn   = 1'b1;
        tready = 1'b1;
        tick(5);
        chk("t6_flushed", 64'(beats.size()), 64'd0);
        do_start(1, 1'b0);
        send(7);
        wait_beats(4, "t6_wait");
        tick(2);
        chk("t6_count", 64'(beats.size()), 64'd4);
        if (beats.size() >= 4) begin
            chk("t6_beat0", 64'(beats[0]), 64'(bt(1'b0, 0, 0, smp(7, 0))));
            chk("t6_beat3", 64'(beats[3]), 64'(bt(1'b1, 0, 3, smp(7, 3))));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
